// File: rtl/ram_arbiter.sv
// Purpose: round-robin arbiter/sequencer putting two masters' read/write commands onto one RAM port.
// Latency: command accepted in cycle T drives the RAM in T+1; read response appears in T+1+RD_LAT.
// Backpressure: at most one mN_req_ready per cycle, from valids and FSM; responses cannot be stalled.
module ram_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_din,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_dout
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] burst_cnt;
    logic             last;       // master granted most recently (1 after reset so m0 wins first tie)

    logic             gnt0;
    logic             gnt1;
    logic             any_gnt;
    logic             g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [1:0]       g_state;

    logic             rd_tag;     // owner of the read currently on ram_re
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_tag;
    logic [RD_LAT:0]   vld_ext;
    logic [RD_LAT:0]   tag_ext;

    // Grant decision: single requester always wins; on a tie the owner keeps
    // the port until its burst is exhausted, otherwise the non-last master wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (m0_req_valid && !m1_req_valid) begin
                gnt0 = 1'b1;
            end else if (m1_req_valid && !m0_req_valid) begin
                gnt1 = 1'b1;
            end else if (m0_req_valid && m1_req_valid) begin
                case (state)
                    OWN0: begin
                        if (burst_cnt < MAX_CNT) gnt0 = 1'b1;
                        else                     gnt1 = 1'b1;
                    end
                    OWN1: begin
                        if (burst_cnt < MAX_CNT) gnt1 = 1'b1;
                        else                     gnt0 = 1'b1;
                    end
                    default: begin
                        if (last) gnt0 = 1'b1;
                        else      gnt1 = 1'b1;
                    end
                endcase
            end
        end
    end

    assign m0_req_ready = gnt0;
    assign m1_req_ready = gnt1;
    assign any_gnt      = gnt0 | gnt1;
    assign g_we         = gnt1 ? m1_req_we    : m0_req_we;
    assign g_addr       = gnt1 ? m1_req_addr  : m0_req_addr;
    assign g_wdata      = gnt1 ? m1_req_wdata : m0_req_wdata;
    assign g_state      = gnt1 ? OWN1 : OWN0;

    // Ownership FSM and burst counter; a grant to a new owner restarts the burst at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last      <= 1'b1;
        end else if (!any_gnt) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            last <= gnt1;
            if (state == g_state) begin
                if (burst_cnt != MAX_CNT) burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
                state     <= g_state;
                burst_cnt <= CNT_W'(1);
            end
        end
    end

    // Register the granted command onto the RAM port; enables are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_din  <= '0;
            ram_rd_addr <= '0;
            rd_tag      <= 1'b0;
        end else begin
            ram_we <= any_gnt & g_we;
            ram_re <= any_gnt & ~g_we;
            if (any_gnt && g_we) begin
                ram_wr_addr <= g_addr;
                ram_wr_din  <= g_wdata;
            end
            if (any_gnt && !g_we) begin
                ram_rd_addr <= g_addr;
                rd_tag      <= gnt1;
            end
        end
    end

    assign vld_ext = {pipe_vld, ram_re};
    assign tag_ext = {pipe_tag, rd_tag};

    // Read-tag pipe: follows the RAM read latency so each response lands on its issuer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld <= '0;
            pipe_tag <= '0;
        end else begin
            pipe_vld <= vld_ext[RD_LAT-1:0];
            pipe_tag <= tag_ext[RD_LAT-1:0];
        end
    end

    // Gating with rst suppresses a response whose read was in flight when reset hit.
    assign m0_rsp_valid = rst & pipe_vld[RD_LAT-1] & ~pipe_tag[RD_LAT-1];
    assign m1_rsp_valid = rst & pipe_vld[RD_LAT-1] &  pipe_tag[RD_LAT-1];
    assign m0_rsp_rdata = ram_rd_dout;
    assign m1_rsp_rdata = ram_rd_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
    logic [7:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic       m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
    logic [7:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic       ram_we, ram_re;
    logic [7:0] ram_wr_addr, ram_wr_din, ram_rd_addr, ram_rd_dout;

    int n_vec = 0;
    int n_err = 0;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_din(ram_wr_din),
        .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_rd_dout(ram_rd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behavioural model, read latency 1
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_din;
        if (ram_re) ram_rd_dout <= mem[ram_rd_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic drv0(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d;
    endtask

    task automatic drv1(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d;
    endtask

    bit exp_g0 [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

    initial begin
        // ---- 1: reset with both valid
        rst = 1'b0;
        drv0(1'b1, 1'b1, 8'h33, 8'h44);
        drv1(1'b1, 1'b0, 8'h55, 8'h00);
        cyc();
        for (int i = 0; i < 3; i++) begin
            neg();
            check("rst_ready0", m0_req_ready, 0);
            check("rst_ready1", m1_req_ready, 0);
            check("rst_ram_en", {ram_we, ram_re}, 0);
            check("rst_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
            cyc();
        end
        check("rst_wr_addr", ram_wr_addr, 0);
        rst = 1'b1;
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("idle_readies", {m0_req_ready, m1_req_ready}, 0);
        cyc();

        // ---- 2: single write then read by m0
        drv0(1'b1, 1'b1, 8'h10, 8'hA5);
        neg();
        check("t2_wr_ready0", m0_req_ready, 1);
        check("t2_wr_ready1", m1_req_ready, 0);
        cyc();
        drv0(1'b1, 1'b0, 8'h10, 8'h00);
        neg();
        check("t2_ram_we", ram_we, 1);
        check("t2_wr_addr", ram_wr_addr, 8'h10);
        check("t2_wr_din", ram_wr_din, 8'hA5);
        check("t2_ram_re_lo", ram_re, 0);
        check("t2_rd_ready0", m0_req_ready, 1);
        cyc();
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("t2_ram_re", ram_re, 1);
        check("t2_rd_addr", ram_rd_addr, 8'h10);
        check("t2_ram_we_lo", ram_we, 0);
        cyc();
        neg();
        check("t2_rsp0_vld", m0_rsp_valid, 1);
        check("t2_rsp0_dat", m0_rsp_rdata, 8'hA5);
        check("t2_rsp1_vld", m1_rsp_valid, 0);
        cyc();
        neg();
        check("t2_rsp0_done", m0_rsp_valid, 0);
        cyc();

        // ---- preload 0x01=0x11, 0x02=0x22 through m1 (leaves last=m1)
        drv1(1'b1, 1'b1, 8'h01, 8'h11);
        neg();
        check("pre_ready1_a", m1_req_ready, 1);
        cyc();
        drv1(1'b1, 1'b1, 8'h02, 8'h22);
        neg();
        check("pre_ready1_b", m1_req_ready, 1);
        check("pre_wr_a", {ram_wr_addr, ram_wr_din}, 16'h0111);
        cyc();
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("pre_wr_b", {ram_wr_addr, ram_wr_din}, 16'h0222);
        cyc();

        // ---- 3: contention, 12 cycles both valid
        drv0(1'b1, 1'b1, 8'h40, 8'hA0);
        drv1(1'b1, 1'b1, 8'h41, 8'hB1);
        for (int i = 0; i < 12; i++) begin
            neg();
            check("t3_ready0", m0_req_ready, exp_g0[i]);
            check("t3_ready1", m1_req_ready, !exp_g0[i]);
            if (i > 0) begin
                check("t3_ram_we", ram_we, 1);
                check("t3_wr_addr", ram_wr_addr, exp_g0[i-1] ? 8'h40 : 8'h41);
            end
            cyc();
        end
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("t3_last_we", ram_we, 1);
        check("t3_last_addr", ram_wr_addr, 8'h40);
        cyc();

        // ---- 4: owner drops valid
        drv0(1'b1, 1'b1, 8'h50, 8'hC0);
        neg(); check("t4_b0_ready0", m0_req_ready, 1); cyc();
        neg(); check("t4_b1_ready0", m0_req_ready, 1); cyc();
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        drv1(1'b1, 1'b1, 8'h51, 8'hD1);
        neg();
        check("t4_b2_ready", {m0_req_ready, m1_req_ready}, 2'b01);
        cyc();
        drv0(1'b1, 1'b1, 8'h50, 8'hC0);
        for (int i = 0; i < 3; i++) begin
            neg();
            check("t4_m1_burst", {m0_req_ready, m1_req_ready}, 2'b01);
            cyc();
        end
        neg();
        check("t4_b6_m0_wins", {m0_req_ready, m1_req_ready}, 2'b10);
        cyc();
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("t4_b7_ready", {m0_req_ready, m1_req_ready}, 2'b01);
        cyc();
        drv0(1'b1, 1'b1, 8'h50, 8'hC0);
        neg();
        check("t4_b8_ready", {m0_req_ready, m1_req_ready}, 2'b01);
        cyc();
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("t4_b9_m1_idle", {m0_req_ready, m1_req_ready}, 2'b10);
        cyc();
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("t4_b10_we", {ram_we, ram_wr_addr}, 9'h150);
        cyc();

        // ---- 5: interleaved reads
        drv0(1'b1, 1'b0, 8'h01, 8'h00);
        neg(); check("t5_c0_ready0", m0_req_ready, 1); cyc();
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        drv1(1'b1, 1'b0, 8'h02, 8'h00);
        neg();
        check("t5_c1_ready1", m1_req_ready, 1);
        check("t5_c1_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
        cyc();
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        drv0(1'b1, 1'b0, 8'h02, 8'h00);
        neg();
        check("t5_c2_ready0", m0_req_ready, 1);
        check("t5_c2_rsp", {m0_rsp_valid, m1_rsp_valid}, 2'b10);
        check("t5_c2_dat", m0_rsp_rdata, 8'h11);
        cyc();
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        drv1(1'b1, 1'b0, 8'h01, 8'h00);
        neg();
        check("t5_c3_ready1", m1_req_ready, 1);
        check("t5_c3_rsp", {m0_rsp_valid, m1_rsp_valid}, 2'b01);
        check("t5_c3_dat", m1_rsp_rdata, 8'h22);
        cyc();
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("t5_c4_rsp", {m0_rsp_valid, m1_rsp_valid}, 2'b10);
        check("t5_c4_dat", m0_rsp_rdata, 8'h22);
        cyc();
        neg();
        check("t5_c5_rsp", {m0_rsp_valid, m1_rsp_valid}, 2'b01);
        check("t5_c5_dat", m1_rsp_rdata, 8'h11);
        cyc();
        neg();
        check("t5_c6_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
        cyc();

        // ---- 6: reset while a read is in flight
        drv0(1'b1, 1'b0, 8'h01, 8'h00);
        neg(); check("t6_d0_ready0", m0_req_ready, 1); cyc();
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        neg(); check("t6_d1_ram_re", ram_re, 1); cyc();
        rst = 1'b0;
        drv0(1'b1, 1'b1, 8'h60, 8'hE0);
        drv1(1'b1, 1'b1, 8'h61, 8'hF1);
        neg();
        check("t6_d2_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
        check("t6_d2_ready", {m0_req_ready, m1_req_ready}, 0);
        cyc();
        rst = 1'b1;
        neg();
        check("t6_d3_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
        check("t6_d3_ready", {m0_req_ready, m1_req_ready}, 2'b10);
        check("t6_d3_ram_en", {ram_we, ram_re}, 0);
        cyc();
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        neg();
        check("t6_d4_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
        check("t6_d4_we", {ram_we, ram_wr_addr, ram_wr_din}, 17'h160E0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
